// File: rtl/frame_write_ctrl.sv
// Frame writer: drains a show-ahead FIFO into a double-buffered frame store through a
// burst-oriented write arbiter channel, alternating buffers on each completed frame.
module frame_write_ctrl #(
  parameter int unsigned MEM_DATA_BITS = 32,
  parameter int unsigned ADDR_BITS     = 25,
  parameter int unsigned BURST_LEN     = 128,
  parameter int unsigned FRAME_WORDS   = 307200,
  parameter int unsigned BASE0         = 0,
  parameter int unsigned BASE1         = 2097152
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [9:0]               fifo_rdusedw,
  output logic                     fifo_rd_en,
  input  logic [MEM_DATA_BITS-1:0] fifo_rd_data,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     frame_done,
  output logic                     rd_buf_sel,
  output logic                     len_err
);

  localparam logic [31:0]          BurstLen32   = 32'(BURST_LEN);
  localparam logic [31:0]          FrameWords32 = 32'(FRAME_WORDS);
  localparam logic [ADDR_BITS-1:0] Base0Addr    = ADDR_BITS'(BASE0);
  localparam logic [ADDR_BITS-1:0] Base1Addr    = ADDR_BITS'(BASE1);

  typedef enum logic [1:0] {StIdle, StWaitData, StBurst, StDone} state_e;

  state_e               state_q, state_d;
  logic [31:0]          offset_q, offset_d;
  logic [ADDR_BITS-1:0] base_q, base_d;
  logic [9:0]           len_q, len_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 req_q, req_d;
  logic [10:0]          beats_q, beats_d;
  logic                 pending_q, pending_d;
  logic                 wr_buf_q, wr_buf_d;
  logic                 rd_buf_sel_q, rd_buf_sel_d;
  logic                 len_err_q, len_err_d;

  logic [31:0] remaining;
  logic [31:0] nlen;
  logic [31:0] new_offset;
  logic [10:0] beats_now;

  assign remaining  = FrameWords32 - offset_q;
  assign nlen       = (remaining < BurstLen32) ? remaining : BurstLen32;
  assign new_offset = offset_q + {22'd0, len_q};

  // Saturate so a runaway arbiter cannot wrap back to a matching count.
  always_comb begin
    beats_now = beats_q;
    if (wr_burst_data_req && (beats_q != 11'h7ff)) begin
      beats_now = beats_q + 11'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    base_d       = base_q;
    len_d        = len_q;
    addr_d       = addr_q;
    req_d        = req_q;
    beats_d      = beats_q;
    pending_d    = pending_q;
    wr_buf_d     = wr_buf_q;
    rd_buf_sel_d = rd_buf_sel_q;
    len_err_d    = len_err_q;

    unique case (state_q)
      StIdle: begin
        if (frame_start || pending_q) begin
          base_d    = wr_buf_q ? Base1Addr : Base0Addr;
          offset_d  = 32'd0;
          pending_d = 1'b0;
          state_d   = StWaitData;
        end
      end
      StWaitData: begin
        if (frame_start) begin
          offset_d = 32'd0;
        end else if ({22'd0, fifo_rdusedw} >= nlen) begin
          len_d   = nlen[9:0];
          addr_d  = base_q + offset_q[ADDR_BITS-1:0];
          req_d   = 1'b1;
          beats_d = 11'd0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (wr_burst_finish) begin
          req_d = 1'b0;
          if (beats_now != {1'b0, len_q}) begin
            len_err_d = 1'b1;
          end
          // A start seen during the burst restarts the same buffer and suppresses DONE.
          if (pending_q || frame_start) begin
            pending_d = 1'b0;
            offset_d  = 32'd0;
            state_d   = StWaitData;
          end else begin
            offset_d = new_offset;
            state_d  = (new_offset >= FrameWords32) ? StDone : StWaitData;
          end
        end else begin
          beats_d = beats_now;
          if (frame_start) begin
            pending_d = 1'b1;
          end
        end
      end
      StDone: begin
        rd_buf_sel_d = wr_buf_q;
        wr_buf_d     = ~wr_buf_q;
        state_d      = StIdle;
        if (frame_start) begin
          pending_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      offset_q     <= 32'd0;
      base_q       <= '0;
      len_q        <= 10'd0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      beats_q      <= 11'd0;
      pending_q    <= 1'b0;
      wr_buf_q     <= 1'b0;
      rd_buf_sel_q <= 1'b1;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      base_q       <= base_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      req_q        <= req_d;
      beats_q      <= beats_d;
      pending_q    <= pending_d;
      wr_buf_q     <= wr_buf_d;
      rd_buf_sel_q <= rd_buf_sel_d;
      len_err_q    <= len_err_d;
    end
  end

  // Data path is a straight wire so the word presented is exactly the word popped.
  assign fifo_rd_en    = (state_q == StBurst) && wr_burst_data_req;
  assign wr_burst_data = fifo_rd_data;
  assign wr_burst_req  = req_q;
  assign wr_burst_len  = len_q;
  assign wr_burst_addr = addr_q;
  assign frame_done    = (state_q == StDone);
  assign rd_buf_sel    = rd_buf_sel_q;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Randomized bench for frame_write_ctrl: a FIFO of sequential words, a scripted arbiter
// and a frame-level model of the expected burst list, buffer alternation and flags.
module tb_frame_write_ctrl;

  localparam int unsigned DataBits   = 32;
  localparam int unsigned AddrBits   = 25;
  localparam int unsigned BurstLen   = 128;
  localparam int unsigned FrameWords = 300;
  localparam int unsigned Base0      = 0;
  localparam int unsigned Base1      = 2097152;

  logic                mem_clk;
  logic                rst;
  logic                frame_start;
  logic [9:0]          fifo_rdusedw;
  logic                fifo_rd_en;
  logic [DataBits-1:0] fifo_rd_data;
  logic                wr_burst_req;
  logic [9:0]          wr_burst_len;
  logic [AddrBits-1:0] wr_burst_addr;
  logic                wr_burst_data_req;
  logic [DataBits-1:0] wr_burst_data;
  logic                wr_burst_finish;
  logic                frame_done;
  logic                rd_buf_sel;
  logic                len_err;

  frame_write_ctrl #(
    .MEM_DATA_BITS(DataBits),
    .ADDR_BITS    (AddrBits),
    .BURST_LEN    (BurstLen),
    .FRAME_WORDS  (FrameWords),
    .BASE0        (Base0),
    .BASE1        (Base1)
  ) dut (
    .mem_clk          (mem_clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .fifo_rdusedw     (fifo_rdusedw),
    .fifo_rd_en       (fifo_rd_en),
    .fifo_rd_data     (fifo_rd_data),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data    (wr_burst_data),
    .wr_burst_finish  (wr_burst_finish),
    .frame_done       (frame_done),
    .rd_buf_sel       (rd_buf_sel),
    .len_err          (len_err)
  );

  int          n_checks;
  int          n_errors;
  int          done_cnt;
  logic [31:0] fifo_head;
  logic [31:0] exp_word;
  bit          wr_buf_m;

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  // Show-ahead FIFO holding an ascending word sequence; each pop exposes the next word.
  initial fifo_head = 32'h1000_0000;
  always @(posedge mem_clk) if (fifo_rd_en) fifo_head <= fifo_head + 32'd1;
  assign fifo_rd_data = fifo_head;

  initial done_cnt = 0;
  always @(negedge mem_clk) if (frame_done) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic end_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge mem_clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_req();
    int cyc = 0;
    while (!wr_burst_req && cyc < 2000) begin
      @(negedge mem_clk);
      cyc++;
    end
    if (!wr_burst_req) begin
      check_eq("req_timeout", 64'd0, 64'd1);
      end_sim();
    end
  endtask

  task automatic do_burst(input int exp_len, input longint exp_addr, input int n_beats,
                          input bit throttle, input bit restart_mid, input bit start_after);
    int beats = 0;
    bit first = 1'b1;
    bit dr;
    wait_req();
    check_eq("burst_len", wr_burst_len, exp_len);
    check_eq("burst_addr", wr_burst_addr, exp_addr);
    while (beats < n_beats) begin
      dr = throttle ? ($urandom_range(2, 0) != 0) : 1'b1;
      wr_burst_data_req = dr;
      frame_start = restart_mid && first;
      first = 1'b0;
      #1;
      check_eq("rd_en_follows_req", fifo_rd_en, dr);
      check_eq("req_held", wr_burst_req, 1);
      check_eq("len_stable", wr_burst_len, exp_len);
      check_eq("addr_stable", wr_burst_addr, exp_addr);
      if (dr) begin
        check_eq("wr_data_order", wr_burst_data, exp_word);
        exp_word++;
        beats++;
      end
      @(negedge mem_clk);
    end
    wr_burst_data_req = 1'b0;
    frame_start = 1'b0;
    wr_burst_finish = 1'b1;
    @(negedge mem_clk);
    wr_burst_finish = 1'b0;
    check_eq("req_drop_after_finish", wr_burst_req, 0);
    if (start_after) pulse_start();
  endtask

  // Model: a frame is walked in BurstLen chunks from offset 0, addresses relative to the
  // buffer currently being written; a restart returns to offset 0 of the same buffer.
  task automatic run_frame(input bit do_start, input bit throttle, input int restart_burst,
                           input int short_burst, input bit start_in_done);
    longint base = wr_buf_m ? longint'(Base1) : longint'(Base0);
    int d0 = done_cnt;
    int off = 0;
    int idx = 0;
    int len;
    bit rs;
    bit last;
    if (do_start) pulse_start();
    while (off < FrameWords) begin
      len  = (FrameWords - off < BurstLen) ? (FrameWords - off) : BurstLen;
      rs   = (idx == restart_burst);
      last = (off + len >= FrameWords) && !rs;
      do_burst(len, (base + off) % (64'd1 << AddrBits), (idx == short_burst) ? len - 1 : len,
               throttle, rs, last && start_in_done);
      off = rs ? 0 : off + len;
      idx++;
    end
    repeat (2) @(negedge mem_clk);
    check_eq("frame_done_pulses", done_cnt - d0, 1);
    check_eq("rd_buf_sel", rd_buf_sel, wr_buf_m);
    wr_buf_m = ~wr_buf_m;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_req"}, wr_burst_req, 0);
    check_eq({tag, "_rd_en"}, fifo_rd_en, 0);
    check_eq({tag, "_done"}, frame_done, 0);
    check_eq({tag, "_len_err"}, len_err, 0);
    check_eq({tag, "_len"}, wr_burst_len, 0);
    check_eq({tag, "_addr"}, wr_burst_addr, 0);
    check_eq({tag, "_rd_buf_sel"}, rd_buf_sel, 1);
  endtask

  initial begin
    #500000;
    check_eq("watchdog", 64'd0, 64'd1);
    end_sim();
  end

  initial begin
    bit saw;
    n_checks = 0;
    n_errors = 0;
    exp_word = 32'h1000_0000;
    wr_buf_m = 1'b0;
    rst = 1'b1;
    frame_start = 1'b0;
    fifo_rdusedw = 10'd1023;
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    repeat (3) @(negedge mem_clk);
    check_reset_state("rst");
    rst = 1'b0;

    // Idle with a full FIFO and stray arbiter strobes: nothing may happen.
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_burst_data_req = i[0];
      wr_burst_finish = i[1];
      #1;
      saw = saw | wr_burst_req | fifo_rd_en;
      @(negedge mem_clk);
    end
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    check_eq("idle_no_activity", saw, 0);
    check_reset_state("idle");

    // Nominal frame into buffer 0, then the next lands in buffer 1.
    run_frame(1'b1, 1'b0, -1, -1, 1'b0);
    check_eq("after_frame0_rd_buf", rd_buf_sel, 0);

    // Fill threshold: 100 words is not enough for a 128-word burst.
    fifo_rdusedw = 10'd100;
    pulse_start();
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_burst_data_req = 1'b1;
      wr_burst_finish = i[0];
      #1;
      saw = saw | wr_burst_req | fifo_rd_en;
      @(negedge mem_clk);
    end
    wr_burst_data_req = 1'b0;
    wr_burst_finish = 1'b0;
    check_eq("req_low_under_fill", saw, 0);
    fifo_rdusedw = 10'd128;
    #1;
    check_eq("req_not_early", wr_burst_req, 0);
    @(negedge mem_clk);
    check_eq("req_one_cycle_later", wr_burst_req, 1);
    run_frame(1'b0, 1'b0, -1, -1, 1'b0);

    // Restart during the second burst of a buffer-0 frame.
    fifo_rdusedw = 10'd1023;
    run_frame(1'b1, 1'b0, 1, -1, 1'b0);

    // Arbiter under-delivers one beat on the first burst.
    check_eq("len_err_clear", len_err, 0);
    run_frame(1'b1, 1'b0, -1, 0, 1'b0);
    check_eq("len_err_sticky", len_err, 1);

    // Reset in the middle of a burst.
    pulse_start();
    wait_req();
    for (int i = 0; i < 5; i++) begin
      wr_burst_data_req = 1'b1;
      exp_word++;
      @(negedge mem_clk);
    end
    rst = 1'b1;
    #1;
    check_reset_state("mid_rst");
    @(negedge mem_clk);
    wr_burst_data_req = 1'b0;
    rst = 1'b0;
    wr_buf_m = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      saw = saw | wr_burst_req;
      @(negedge mem_clk);
    end
    check_eq("no_req_after_rst", saw, 0);
    run_frame(1'b1, 1'b0, -1, -1, 1'b0);

    // Three throttled frames; the second is launched by a start landing in DONE.
    fifo_rdusedw = 10'($urandom_range(1023, 128));
    run_frame(1'b1, 1'b1, -1, -1, 1'b1);
    fifo_rdusedw = 10'($urandom_range(1023, 128));
    run_frame(1'b0, 1'b1, -1, -1, 1'b0);
    fifo_rdusedw = 10'($urandom_range(1023, 128));
    run_frame(1'b1, 1'b1, -1, -1, 1'b0);
    check_eq("fifo_pops_total", fifo_head, exp_word);
    check_eq("len_err_clean_after_rst", len_err, 0);

    end_sim();
  end

endmodule
